// File: rtl/led_pattern_pkg.sv
// LED pattern generator shared definitions.
// Mode encodings, direction and phase types.
package led_pattern_pkg;

  localparam logic [2:0] MODE_FILL_L         = 3'd0;
  localparam logic [2:0] MODE_FILL_R         = 3'd1;
  localparam logic [2:0] MODE_CHASE_L        = 3'd2;
  localparam logic [2:0] MODE_BOUNCE         = 3'd3;
  localparam logic [2:0] MODE_FILL_DRAIN     = 3'd4;
  localparam logic [2:0] MODE_RESET_SENTINEL = 3'd7;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_DRAIN = 1'b1
  } phase_t;

  function automatic logic mode_valid(input logic [2:0] m);
    return (m <= MODE_FILL_DRAIN);
  endfunction

endpackage

// File: rtl/led_pattern_gen_if.sv
// Control/status bundle of the LED pattern generator.
// master drives control, slave drives the LED bank.
interface led_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
);
  logic             en;
  logic [2:0]       mode;
  logic [DIV_W-1:0] div;
  logic [WIDTH-1:0] out;
  logic             step;
  logic             wrap;

  modport master (
    output en, mode, div,
    input  out, step, wrap
  );

  modport slave (
    input  en, mode, div,
    output out, step, wrap
  );
endinterface

// File: rtl/led_tick_div.sv
// Programmable prescaler: one tick every div+1 enabled clocks.
// clr restarts the count and suppresses the tick.
module led_tick_div #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count;
  logic             hit;

  assign hit  = (count == div);
  assign tick = en && !clr && hit;

  // count up to div, hold while disabled, restart on clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= hit ? '0 : count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Run-time selectable LED pattern generator.
// Holds mode, LED state, bounce direction and fill/drain phase.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic         clk,
  input  logic         reset,
  led_pattern_gen_if.slave bus
);

  logic [2:0]       mode_q;
  logic [WIDTH-1:0] out_q;
  logic             step_q;
  logic             wrap_q;
  dir_t             dir_q;
  phase_t           ph_q;

  logic             load;
  logic             tick;
  logic [WIDTH-1:0] start;

  logic [WIDTH-1:0] nxt_out;
  dir_t             nxt_dir;
  phase_t           nxt_ph;
  logic             nxt_wrap;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  assign load = (bus.mode != mode_q);

  led_tick_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (bus.en),
    .clr  (load),
    .div  (bus.div),
    .tick (tick)
  );

  // start value of the mode being loaded
  always_comb begin
    start = '0;
    if (bus.mode == MODE_CHASE_L ||
        bus.mode == MODE_BOUNCE)
      start = ONE;
  end

  // next LED state for one step of the active mode
  always_comb begin
    nxt_out  = out_q;
    nxt_dir  = dir_q;
    nxt_ph   = ph_q;
    nxt_wrap = 1'b0;
    unique case (1'b1)
      (mode_q == MODE_FILL_L): begin
        if (&out_q) begin
          nxt_out  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_out = {out_q[WIDTH-2:0], 1'b1};
        end
      end
      (mode_q == MODE_FILL_R): begin
        if (&out_q) begin
          nxt_out  = '0;
          nxt_wrap = 1'b1;
        end else begin
          nxt_out = {1'b1, out_q[WIDTH-1:1]};
        end
      end
      (mode_q == MODE_CHASE_L): begin
        nxt_out  = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
        nxt_wrap = out_q[WIDTH-1];
      end
      (mode_q == MODE_BOUNCE): begin
        if (dir_q == DIR_LEFT) begin
          nxt_out = out_q << 1;
          if (nxt_out[WIDTH-1])
            nxt_dir = DIR_RIGHT;
        end else begin
          nxt_out = out_q >> 1;
          if (nxt_out == ONE) begin
            nxt_dir  = DIR_LEFT;
            nxt_wrap = 1'b1;
          end
        end
      end
      (mode_q == MODE_FILL_DRAIN): begin
        if (ph_q == PH_FILL) begin
          nxt_out = {out_q[WIDTH-2:0], 1'b1};
          if (&nxt_out)
            nxt_ph = PH_DRAIN;
        end else begin
          nxt_out = {out_q[WIDTH-2:0], 1'b0};
          if (nxt_out == '0) begin
            nxt_ph   = PH_FILL;
            nxt_wrap = 1'b1;
          end
        end
      end
      default: begin
        nxt_out = '0;
      end
    endcase
  end

  // mode load beats a step; reserved modes never step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_RESET_SENTINEL;
      out_q  <= '0;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      dir_q  <= DIR_LEFT;
      ph_q   <= PH_FILL;
    end else begin
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      if (load) begin
        mode_q <= bus.mode;
        out_q  <= start;
        dir_q  <= DIR_LEFT;
        ph_q   <= PH_FILL;
      end else if (tick && mode_valid(mode_q)) begin
        out_q  <= nxt_out;
        dir_q  <= nxt_dir;
        ph_q   <= nxt_ph;
        step_q <= 1'b1;
        wrap_q <= nxt_wrap;
      end
    end
  end

  assign bus.out  = out_q;
  assign bus.step = step_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: vector table, corner sequences,
// and random run against a position-index reference model.
module tb_led_pattern_gen;

  localparam int W  = 8;
  localparam int DW = 24;

  logic clk;
  logic reset;

  led_pattern_gen_if #(.WIDTH(W), .DIV_W(DW)) bus ();

  led_pattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: pattern = f(mode, position index)
  int          mq;
  int          k;
  logic [DW-1:0] mcnt;
  logic        mstep;
  logic        mwrap;

  function automatic int period(input int m);
    case (m)
      0, 1:    return W + 1;
      2:       return W;
      3:       return 2 * W - 2;
      4:       return 2 * W;
      default: return 1;
    endcase
  endfunction

  function automatic logic [W-1:0] ones(input int n);
    longint v;
    v = (64'd1 << n) - 1;
    return W'(v);
  endfunction

  function automatic logic [W-1:0] pat(input int m, input int idx);
    longint v;
    v = 0;
    case (m)
      0: v = (64'd1 << idx) - 1;
      1: v = ((64'd1 << idx) - 1) << (W - idx);
      2: v = 64'd1 << idx;
      3: v = 64'd1 << ((idx < W) ? idx : (2 * W - 2 - idx));
      4: v = (idx <= W) ? ((64'd1 << idx) - 1)
                        : (((64'd1 << W) - 1) << (idx - W));
      default: v = 0;
    endcase
    return W'(v);
  endfunction

  task automatic model_reset();
    mq    = 7;
    k     = 0;
    mcnt  = '0;
    mstep = 1'b0;
    mwrap = 1'b0;
  endtask

  task automatic model_edge();
    mstep = 1'b0;
    mwrap = 1'b0;
    if (int'(bus.mode) != mq) begin
      mq   = int'(bus.mode);
      k    = 0;
      mcnt = '0;
    end else if (bus.en) begin
      if (mcnt == bus.div) begin
        mcnt = '0;
        if (mq <= 4) begin
          k     = (k + 1) % period(mq);
          mstep = 1'b1;
          mwrap = (k == 0);
        end
      end else begin
        mcnt = mcnt + 1'b1;
      end
    end
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               name, act, exp, $time);
    end
  endtask

  // one clock: advance model, then compare #1 after the edge
  task automatic cycle();
    @(posedge clk);
    if (!reset) model_edge();
    #1;
    chk("model_out", 32'(bus.out), 32'(pat(mq, k)));
    chk("model_step", 32'(bus.step), 32'(mstep));
    chk("model_wrap", 32'(bus.wrap), 32'(mwrap));
  endtask

  typedef struct {
    logic          en;
    logic [2:0]    mode;
    logic [DW-1:0] div;
    logic [W-1:0]  out;
    logic          step;
    logic          wrap;
  } vec_t;

  vec_t tbl[11];

  logic [W-1:0] bexp[14];

  initial begin
    int nst;
    int nwr;
    bit found;

    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0};
    tbl[1]  = '{1, 0, 0, 8'h01, 1, 0};
    tbl[2]  = '{1, 0, 0, 8'h03, 1, 0};
    tbl[3]  = '{1, 0, 0, 8'h07, 1, 0};
    tbl[4]  = '{1, 0, 0, 8'h0F, 1, 0};
    tbl[5]  = '{1, 0, 0, 8'h1F, 1, 0};
    tbl[6]  = '{1, 0, 0, 8'h3F, 1, 0};
    tbl[7]  = '{1, 0, 0, 8'h7F, 1, 0};
    tbl[8]  = '{1, 0, 0, 8'hFF, 1, 0};
    tbl[9]  = '{1, 0, 0, 8'h00, 1, 1};
    tbl[10] = '{1, 0, 0, 8'h01, 1, 0};

    bexp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
             8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};

    // reset state
    reset    = 1'b1;
    bus.en   = 1'b1;
    bus.mode = 3'd0;
    bus.div  = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(bus.out), 32'h0);
    chk("rst_step", 32'(bus.step), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    reset = 1'b0;

    // FILL_L, div=0: load then full sequence with wrap
    for (int i = 0; i < 11; i++) begin
      bus.en   = tbl[i].en;
      bus.mode = tbl[i].mode;
      bus.div  = tbl[i].div;
      cycle();
      chk($sformatf("tbl%0d_out", i), 32'(bus.out), 32'(tbl[i].out));
      chk($sformatf("tbl%0d_step", i), 32'(bus.step), 32'(tbl[i].step));
      chk($sformatf("tbl%0d_wrap", i), 32'(bus.wrap), 32'(tbl[i].wrap));
    end

    // mode switch 0->2 at 3F with a tick due
    bus.div = DW'(2);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.out == 8'h3F && bus.step) begin
        found = 1;
        break;
      end
    end
    chk("reach_3f", 32'(found), 32'h1);
    cycle();
    cycle();
    bus.mode = 3'd2;
    cycle();
    chk("sw_out", 32'(bus.out), 32'h01);
    chk("sw_step", 32'(bus.step), 32'h0);
    chk("sw_wrap", 32'(bus.wrap), 32'h0);
    cycle();
    cycle();
    chk("sw_cnt0_step", 32'(bus.step), 32'h0);
    cycle();
    chk("sw_cnt0_out", 32'(bus.out), 32'h02);
    chk("sw_cnt0_step2", 32'(bus.step), 32'h1);

    // en freeze in CHASE_L at 08
    bus.div = DW'(3);
    found = 0;
    for (int i = 0; i < 60; i++) begin
      cycle();
      if (bus.out == 8'h08 && bus.step) begin
        found = 1;
        break;
      end
    end
    chk("reach_08", 32'(found), 32'h1);
    cycle();
    cycle();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("frz_out", 32'(bus.out), 32'h08);
      chk("frz_step", 32'(bus.step), 32'h0);
    end
    bus.en = 1'b1;
    cycle();
    chk("ren1_out", 32'(bus.out), 32'h08);
    chk("ren1_step", 32'(bus.step), 32'h0);
    cycle();
    chk("ren2_out", 32'(bus.out), 32'h10);
    chk("ren2_step", 32'(bus.step), 32'h1);

    // BOUNCE, div=0: full period
    bus.mode = 3'd3;
    bus.div  = '0;
    cycle();
    chk("bn_load", 32'(bus.out), 32'h01);
    for (int i = 0; i < 14; i++) begin
      cycle();
      chk($sformatf("bn%0d_out", i), 32'(bus.out), 32'(bexp[i]));
      chk($sformatf("bn%0d_wrap", i), 32'(bus.wrap), (i == 13) ? 32'h1 : 32'h0);
    end

    // async reset at 40 heading right
    repeat (8) cycle();
    chk("bn_at40", 32'(bus.out), 32'h40);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_out", 32'(bus.out), 32'h00);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cycle();
    chk("post_rst_load", 32'(bus.out), 32'h01);
    chk("post_rst_step", 32'(bus.step), 32'h0);
    cycle();
    chk("post_rst_left", 32'(bus.out), 32'h02);

    // FILL_DRAIN, div=2: 16 steps over 48 cycles, one wrap
    bus.mode = 3'd4;
    bus.div  = DW'(2);
    cycle();
    chk("fd_load", 32'(bus.out), 32'h00);
    nst = 0;
    nwr = 0;
    for (int i = 0; i < 48; i++) begin
      cycle();
      nst += int'(bus.step);
      nwr += int'(bus.wrap);
      if (i == 26)
        chk("fd_ff", 32'(bus.out), 32'hFE);
    end
    chk("fd_steps", 32'(nst), 32'd16);
    chk("fd_wraps", 32'(nwr), 32'd1);
    chk("fd_end", 32'(bus.out), 32'h00);

    // reserved mode holds zero
    bus.mode = 3'd5;
    bus.div  = '0;
    nst = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      nst += int'(bus.step);
    end
    chk("rsv_out", 32'(bus.out), 32'h00);
    chk("rsv_steps", 32'(nst), 32'd0);

    // random run against the model
    for (int i = 0; i < 800; i++) begin
      bus.en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 29) == 0) begin
        logic [2:0] nm;
        nm = 3'($urandom_range(0, 7));
        if (nm != bus.mode) begin
          bus.mode = nm;
          bus.div  = DW'($urandom_range(0, 3));
        end
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
